// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: synchronizes locked, holds sys_rst_n until lock has settled, and re-asserts it on filtered lock loss.
// Optional lock timeout is built only when PLL_MON_TIMEOUT_EN is defined; otherwise timeout is tied to 0.
module pll_lock_monitor #(
  parameter int unsigned SETTLE_CYCLES  = 1024,
  parameter int unsigned FILTER_CYCLES  = 4,
  parameter int unsigned RELOCK_W       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16000000
) (
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic                locked,
  output logic                sys_rst_n,
  output logic                ready,
  output logic                lost_lock,
  output logic [RELOCK_W-1:0] relock_count,
  output logic                timeout
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned FLT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  // Empty marker scope that shows up in the hierarchy when a cycle count is configured as zero.
  if (SETTLE_CYCLES < 1 || FILTER_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_out_of_range
  end

  typedef enum logic [2:0] {
    RESET_HOLD,
    WAIT_LOCK,
    SETTLE,
    RUN,
    LOST
  } state_t;

  state_t              state, state_nxt;
  logic                locked_m, locked_s;
  logic [SET_W-1:0]    settle_cnt, settle_cnt_nxt;
  logic [FLT_W-1:0]    filt_cnt, filt_cnt_nxt;
  logic                sys_rst_n_nxt, ready_nxt, lost_lock_nxt;
  logic [RELOCK_W-1:0] relock_count_nxt;

  // Next-state and next-output decode
  always_comb begin
    state_nxt        = state;
    settle_cnt_nxt   = settle_cnt;
    filt_cnt_nxt     = filt_cnt;
    sys_rst_n_nxt    = sys_rst_n;
    ready_nxt        = ready;
    lost_lock_nxt    = 1'b0;
    relock_count_nxt = relock_count;
    case (state)
      RESET_HOLD: begin
        state_nxt     = WAIT_LOCK;
        sys_rst_n_nxt = 1'b0;
        ready_nxt     = 1'b0;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt      = SETTLE;
          settle_cnt_nxt = '0;
        end
      end
      SETTLE: begin
        if (!locked_s) begin
          state_nxt      = WAIT_LOCK;
          settle_cnt_nxt = '0;
        end else if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
          state_nxt     = RUN;
          sys_rst_n_nxt = 1'b1;
          ready_nxt     = 1'b1;
          filt_cnt_nxt  = '0;
        end else begin
          settle_cnt_nxt = settle_cnt + SET_W'(1);
        end
      end
      RUN: begin
        if (locked_s) begin
          filt_cnt_nxt = '0;
        end else if (filt_cnt == FLT_W'(FILTER_CYCLES - 1)) begin
          state_nxt     = LOST;
          sys_rst_n_nxt = 1'b0;
          ready_nxt     = 1'b0;
          lost_lock_nxt = 1'b1;
          filt_cnt_nxt  = '0;
          if (relock_count != '1) relock_count_nxt = relock_count + RELOCK_W'(1);
        end else begin
          filt_cnt_nxt = filt_cnt + FLT_W'(1);
        end
      end
      LOST: begin
        state_nxt = WAIT_LOCK;
      end
      default: begin
        state_nxt     = RESET_HOLD;
        sys_rst_n_nxt = 1'b0;
        ready_nxt     = 1'b0;
      end
    endcase
  end

  // State, synchronizer and output registers
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RESET_HOLD;
      locked_m     <= 1'b0;
      locked_s     <= 1'b0;
      settle_cnt   <= '0;
      filt_cnt     <= '0;
      sys_rst_n    <= 1'b0;
      ready        <= 1'b0;
      lost_lock    <= 1'b0;
      relock_count <= '0;
    end else begin
      state        <= state_nxt;
      locked_m     <= locked;
      locked_s     <= locked_m;
      settle_cnt   <= settle_cnt_nxt;
      filt_cnt     <= filt_cnt_nxt;
      sys_rst_n    <= sys_rst_n_nxt;
      ready        <= ready_nxt;
      lost_lock    <= lost_lock_nxt;
      relock_count <= relock_count_nxt;
    end
  end

`ifdef PLL_MON_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            timeout_nxt;

  // Timeout spans SETTLE->WAIT_LOCK bounces; only RUN entry or reset clears it
  always_comb begin
    to_cnt_nxt  = to_cnt;
    timeout_nxt = timeout;
    if (state_nxt == RUN && state != RUN) begin
      to_cnt_nxt  = '0;
      timeout_nxt = 1'b0;
    end else if (state == WAIT_LOCK || state == SETTLE) begin
      if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) timeout_nxt = 1'b1;
      else                                     to_cnt_nxt  = to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      to_cnt  <= to_cnt_nxt;
      timeout <= timeout_nxt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed self-checking bench for pll_lock_monitor (SETTLE=16, FILTER=4, RELOCK_W=2, TIMEOUT=100).
module tb_pll_lock_monitor;

  localparam int unsigned SETTLE  = 16;
  localparam int unsigned FILTER  = 4;
  localparam int unsigned RW      = 2;
  localparam int unsigned TIMEOUT = 100;

  logic          sysclk = 1'b0;
  logic          rst_n;
  logic          locked;
  logic          sys_rst_n;
  logic          ready;
  logic          lost_lock;
  logic [RW-1:0] relock_count;
  logic          timeout;

  int n_tests = 0;
  int n_fail  = 0;

  pll_lock_monitor #(
    .SETTLE_CYCLES (SETTLE),
    .FILTER_CYCLES (FILTER),
    .RELOCK_W      (RW),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .locked      (locked),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .lost_lock   (lost_lock),
    .relock_count(relock_count),
    .timeout     (timeout)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    locked = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (sys_rst_n !== 1'b0 || ready !== 1'b0 || lost_lock !== 1'b0 ||
        relock_count !== 2'd0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got rst=%b rdy=%b lost=%b cnt=%0d to=%b expected 0 0 0 0 0",
               sys_rst_n, ready, lost_lock, relock_count, timeout);
    end
  endtask

  // Release reset mid-cycle with locked high: next edge is edge 0, release at edge 18
  task automatic test_clean_lock();
    rst_n = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      tick();
      if (e == 17) begin
        n_tests++;
        if (sys_rst_n !== 1'b0 || ready !== 1'b0) begin
          n_fail++;
          $display("FAIL clean_lock_e17: got rst=%b rdy=%b expected 0 0", sys_rst_n, ready);
        end
      end
      if (e == 18) begin
        n_tests++;
        if (sys_rst_n !== 1'b1 || ready !== 1'b1 || timeout !== 1'b0) begin
          n_fail++;
          $display("FAIL clean_lock_e18: got rst=%b rdy=%b to=%b expected 1 1 0", sys_rst_n, ready, timeout);
        end
      end
    end
  endtask

  task automatic test_glitch();
    // Short 3-cycle drop must be ignored
    locked = 1'b0;
    repeat (3) tick();
    locked = 1'b1;
    for (int e = 3; e < 9; e++) begin
      tick();
      n_tests++;
      if (sys_rst_n !== 1'b1 || ready !== 1'b1 || lost_lock !== 1'b0 || relock_count !== 2'd0) begin
        n_fail++;
        $display("FAIL glitch_short_e%0d: got rst=%b rdy=%b lost=%b cnt=%0d expected 1 1 0 0",
                 e, sys_rst_n, ready, lost_lock, relock_count);
      end
    end
    // 6-cycle drop: reset falls at edge 5
    locked = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      tick();
      if (e == 4) begin
        n_tests++;
        if (sys_rst_n !== 1'b1 || lost_lock !== 1'b0) begin
          n_fail++;
          $display("FAIL glitch_long_e4: got rst=%b lost=%b expected 1 0", sys_rst_n, lost_lock);
        end
      end
      if (e == 5) begin
        n_tests++;
        if (sys_rst_n !== 1'b0 || ready !== 1'b0 || lost_lock !== 1'b1 || relock_count !== 2'd1) begin
          n_fail++;
          $display("FAIL glitch_long_e5: got rst=%b rdy=%b lost=%b cnt=%0d expected 0 0 1 1",
                   sys_rst_n, ready, lost_lock, relock_count);
        end
      end
    end
    // Relock: next edge is new edge 0
    locked = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      tick();
      if (e == 0) begin
        n_tests++;
        if (lost_lock !== 1'b0) begin
          n_fail++;
          $display("FAIL lost_pulse_width: got lost=%b expected 0", lost_lock);
        end
      end
      if (e == 17) begin
        n_tests++;
        if (sys_rst_n !== 1'b0) begin
          n_fail++;
          $display("FAIL relock_e17: got rst=%b expected 0", sys_rst_n);
        end
      end
      if (e == 18) begin
        n_tests++;
        if (sys_rst_n !== 1'b1 || ready !== 1'b1 || relock_count !== 2'd1) begin
          n_fail++;
          $display("FAIL relock_e18: got rst=%b rdy=%b cnt=%0d expected 1 1 1", sys_rst_n, ready, relock_count);
        end
      end
    end
  endtask

  task automatic test_settle_toggle();
    locked = 1'b0;
    repeat (6) tick();
    n_tests++;
    if (relock_count !== 2'd2 || sys_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL second_loss: got cnt=%0d rst=%b expected 2 0", relock_count, sys_rst_n);
    end
    // Lock at edge 0; low sample at edge 11 is seen by SETTLE at count 10 (edge 13)
    locked = 1'b1;
    repeat (11) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      tick();
      if (e < 18) begin
        n_tests++;
        if (sys_rst_n !== 1'b0 || ready !== 1'b0) begin
          n_fail++;
          $display("FAIL settle_restart_e%0d: got rst=%b rdy=%b expected 0 0", e, sys_rst_n, ready);
        end
      end else begin
        n_tests++;
        if (sys_rst_n !== 1'b1 || ready !== 1'b1 || relock_count !== 2'd2) begin
          n_fail++;
          $display("FAIL settle_restart_e18: got rst=%b rdy=%b cnt=%0d expected 1 1 2",
                   sys_rst_n, ready, relock_count);
        end
      end
    end
  endtask

  task automatic test_saturation();
    for (int k = 3; k <= 5; k++) begin
      locked = 1'b0;
      repeat (6) tick();
      n_tests++;
      if (relock_count !== 2'd3 || lost_lock !== 1'b1) begin
        n_fail++;
        $display("FAIL saturation_loss%0d: got cnt=%0d lost=%b expected 3 1", k, relock_count, lost_lock);
      end
      locked = 1'b1;
      repeat (19) tick();
      n_tests++;
      if (ready !== 1'b1) begin
        n_fail++;
        $display("FAIL saturation_relock%0d: got rdy=%b expected 1", k, ready);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (sys_rst_n !== 1'b0 || ready !== 1'b0 || relock_count !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: got rst=%b rdy=%b cnt=%0d expected 0 0 0", sys_rst_n, ready, relock_count);
    end
    tick();
    rst_n = 1'b1;
    repeat (19) tick();
    n_tests++;
    if (sys_rst_n !== 1'b1 || ready !== 1'b1 || relock_count !== 2'd0) begin
      n_fail++;
      $display("FAIL post_reset_lock: got rst=%b rdy=%b cnt=%0d expected 1 1 0", sys_rst_n, ready, relock_count);
    end
  endtask

  task automatic test_timeout();
    rst_n  = 1'b0;
    locked = 1'b0;
    tick();
    rst_n = 1'b1;
`ifdef PLL_MON_TIMEOUT_EN
    for (int e = 1; e <= 101; e++) begin
      tick();
      if (e == 100) begin
        n_tests++;
        if (timeout !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_e100: got to=%b expected 0", timeout);
        end
      end
      if (e == 101) begin
        n_tests++;
        if (timeout !== 1'b1 || sys_rst_n !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_e101: got to=%b rst=%b expected 1 0", timeout, sys_rst_n);
        end
      end
    end
    repeat (10) tick();
    n_tests++;
    if (timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: got to=%b expected 1", timeout);
    end
    locked = 1'b1;
    repeat (19) tick();
    n_tests++;
    if (timeout !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_clear: got to=%b rdy=%b expected 0 1", timeout, ready);
    end
`else
    repeat (120) tick();
    n_tests++;
    if (timeout !== 1'b0 || sys_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_disabled: got to=%b rst=%b expected 0 0", timeout, sys_rst_n);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_glitch();
    test_settle_toggle();
    test_saturation();
    test_reset_mid_run();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
# pll_lock_monitor

Consumes the PLL `locked` flag and produces the clean system reset and ready status for the rest of the firmware. It is clocked from the PLL reference oscillator, so it keeps running while the PLL is unlocked. It synchronizes `locked`, waits a settle interval after lock, then releases `sys_rst_n`. On a filtered loss of lock it re-asserts reset and counts the relock event.

## Interface
- `SETTLE_CYCLES`, default 1024: consecutive synchronized-locked cycles required before reset release; must be ≥ 1.
- `FILTER_CYCLES`, default 4: consecutive synchronized-unlocked cycles in RUN that declare lock loss; must be ≥ 1.
- `RELOCK_W`, default 8: width of `relock_count`.
- `TIMEOUT_CYCLES`, default 16000000 (1 s at 16 MHz): lock timeout; used only with `PLL_MON_TIMEOUT_EN`.
- `sysclk` in 1: PLL reference clock (16 MHz board oscillator).
- `rst_n` in 1: asynchronous, active-low reset.
- `locked` in 1: PLL lock flag, asynchronous to `sysclk`.
- `sys_rst_n` out 1: system reset, active-low.
- `ready` out 1: high exactly while in RUN.
- `lost_lock` out 1: one-cycle pulse on each declared loss of lock.
- `relock_count` out RELOCK_W: number of declared losses, saturating.
- `timeout` out 1: sticky lock-timeout flag.

## Operation
- `locked` passes through a 2-flop synchronizer, reset to 0. The synchronized output is `locked_s`.
- FSM states are RESET_HOLD, WAIT_LOCK, SETTLE, RUN, LOST.
- **Reset** (`rst_n`=0, asynchronous):
  - State goes to RESET_HOLD.
  - `sys_rst_n`=0, `ready`=0, `lost_lock`=0, `relock_count`=0, `timeout`=0.
  - All counters cleared.
  - Reset mid-operation has the same effect, including clearing `relock_count`.
- **RESET_HOLD**: goes to WAIT_LOCK on the next edge.
- **WAIT_LOCK**: when `locked_s`=1, go to SETTLE with the settle counter at 0.
- **SETTLE**:
  - If `locked_s`=0, return to WAIT_LOCK and clear the settle counter. This does not increment `relock_count`.
  - Otherwise, increment the settle counter.
  - When the counter equals SETTLE_CYCLES-1 and `locked_s`=1, go to RUN. `sys_rst_n` and `ready` rise on that same edge.
- **RUN**:
  - The filter counter increments while `locked_s`=0 and clears while `locked_s`=1.
  - When the counter equals FILTER_CYCLES-1 and `locked_s`=0, go to LOST.
  - On that same edge: `sys_rst_n`=0, `ready`=0, `lost_lock`=1, and `relock_count` increments. `relock_count` saturates at all-ones.
- **LOST**: `lost_lock` returns to 0; go to WAIT_LOCK on the next edge.
- Counter widths are `$clog2` of the respective parameter, minimum 1 bit. Counters never wrap.
- All outputs are registered.
- `sys_rst_n` assertion is asynchronous via `rst_n`. Its deassertion is synchronous to `sysclk`. Consumers in the PLL clock domain re-synchronize the deassertion.

## Timing
- Cycle numbering: edge 0 is the first `sysclk` edge that samples `locked`=1.
- Lock to release:
  - `locked_s`=1 after edge 1.
  - SETTLE is entered at edge 2.
  - `sys_rst_n`/`ready` rise at edge SETTLE_CYCLES+2.
- Loss to reset: with edge 0 sampling `locked`=0, `sys_rst_n` falls at edge FILTER_CYCLES+1.
- Glitch filtering: a `locked` low pulse shorter than FILTER_CYCLES sampled cycles causes no state change in RUN.
- Relock after loss: from LOST the path is WAIT_LOCK, then SETTLE. The full settle interval applies again, with no shortcut.
- A `locked` toggle during SETTLE restarts the settle interval from zero.

## Configuration
- Macro: `PLL_MON_TIMEOUT_EN`.
- **Defined**:
  - A timeout counter runs in WAIT_LOCK and SETTLE. It is not cleared by SETTLE→WAIT_LOCK; it is cleared on entry to RUN or on reset.
  - When the counter reaches TIMEOUT_CYCLES-1, `timeout` sets to 1 and the counter stops.
  - `timeout` is sticky until RUN is entered or `rst_n` is asserted.
  - The FSM continues waiting for lock regardless of `timeout`.
- **Not defined**: no timeout counter is built, and `timeout` is tied to 0.

## Test plan
- **Reset values**: SETTLE_CYCLES=16, FILTER_CYCLES=4. Hold `rst_n`=0 with `locked`=1 → `sys_rst_n`=0, `ready`=0, `relock_count`=0.
- **Clean lock**: release `rst_n`, then `locked`=1 held → `sys_rst_n` and `ready` rise exactly at edge 18 after the first edge sampling `locked`=1.
- **Glitch rejection in RUN**: drop `locked` for 3 cycles → no change, `relock_count`=0. Drop it for 6 cycles → `sys_rst_n` falls at edge 5, `lost_lock` pulses for 1 cycle, `relock_count`=1. Re-raise `locked` → release 18 edges later.
- **Instability during SETTLE**: toggle `locked` low for 1 cycle at settle count 10 → release delayed by a full new 16-cycle interval, `relock_count` unchanged.
- **Saturation and reset mid-run**: RELOCK_W=2 with 5 losses → `relock_count`=3. Assert `rst_n`=0 while in RUN → `sys_rst_n` low immediately (asynchronous), count cleared.
- **Timeout** (`PLL_MON_TIMEOUT_EN` defined, TIMEOUT_CYCLES=100): `locked`=0 → `timeout`=1 at edge 101 after reset release. Raise `locked` → `timeout` clears on RUN entry.
